// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared data-memory types and default widths
package riscv_mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;

   // Records which port issued in the previous cycle
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CPU_RD  = 2'd1,
      ST_DBG_ACK = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - saturating count of cycles the debug port was denied
module dmem_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic starved
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wait_cnt <= '0;
      end else if (inc && (wait_cnt != MAX_CNT)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign starved = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter, CPU priority with bounded debug wait
module dmem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   dmem_state_e state, state_next;
   logic        cpu_grant, dbg_grant, cpu_eligible;
   logic        starved, wait_inc, wait_clr;
   logic        dbg_rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         dbg_rd_q <= 1'b0;
      end else begin
         state <= state_next;
         if (dbg_grant) begin
            dbg_rd_q <= ~dbg_we;
         end
      end
   end

   always_comb begin
      cpu_grant  = 1'b0;
      dbg_grant  = 1'b0;
      state_next = ST_IDLE;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (dbg_req && starved) begin
                  dbg_grant = 1'b1;
               end else if (cpu_req) begin
                  cpu_grant = 1'b1;
               end else if (dbg_req) begin
                  dbg_grant = 1'b1;
               end
            end
            // The held cpu_req here is the load already in flight
            ST_CPU_RD:  dbg_grant = dbg_req;
            ST_DBG_ACK: cpu_grant = cpu_req;
            default: ;
         endcase
      end
      if (dbg_grant) begin
         state_next = ST_DBG_ACK;
      end else if (cpu_grant && !cpu_we) begin
         state_next = ST_CPU_RD;
      end
   end

   assign cpu_eligible = !rst && (state != ST_CPU_RD);
   assign cpu_stall    = cpu_req && ((cpu_grant && !cpu_we) || (cpu_eligible && !cpu_grant));

   assign wait_inc = !rst && (state == ST_IDLE) && dbg_req && !dbg_grant;
   assign wait_clr = dbg_grant || !dbg_req;

   dmem_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .clk     (clk),
      .rst     (rst),
      .inc     (wait_inc),
      .clr     (wait_clr),
      .starved (starved)
   );

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_grant) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_grant) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   assign cpu_rdata = (!rst && (state == ST_CPU_RD)) ? mem_rdata : '0;
   assign dbg_ack   = !rst && (state == ST_DBG_ACK);
   assign dbg_rdata = (dbg_ack && dbg_rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench for dmem_arbiter with behavioural sync memory
module tb_dmem_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_ack;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] mem [256];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_ack   (dbg_ack),
      .dbg_rdata (dbg_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic          en;
      logic          stall;
      logic          ack;
      logic [DW-1:0] crd;
      logic [DW-1:0] drd;
   } exp_t;

   typedef struct {
      logic          rst;
      logic          creq;
      logic          cwe;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwd;
      logic          dreq;
      logic          dwe;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dwd;
      exp_t          e;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];
   exp_t sb [$];
   int   n_vec = 0;
   int   n_miss = 0;

   function automatic vec_t mk(input logic r, input logic creq, input logic cwe, input int caddr,
                               input logic [DW-1:0] cwd, input logic dreq, input logic dwe,
                               input int daddr, input logic [DW-1:0] dwd, input logic en,
                               input logic stall, input logic ack, input logic [DW-1:0] crd,
                               input logic [DW-1:0] drd);
      vec_t v;
      v.rst = r;     v.creq = creq; v.cwe = cwe; v.caddr = AW'(caddr); v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe;   v.daddr = AW'(daddr); v.dwd = dwd;
      v.e.en = en;   v.e.stall = stall; v.e.ack = ack; v.e.crd = crd; v.e.drd = drd;
      return v;
   endfunction

   task automatic chk1(input int idx, input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
      if (act !== req) begin
         n_miss++;
         $display("FAIL vec %0d %s: got %h, expected %h", idx, name, act, req);
      end
   endtask

   initial begin
      // reset held with both ports requesting
      vecs[0]  = mk(1, 1,0,15,0,            1,0,15,0,     0,0,0,0,0);
      vecs[1]  = mk(1, 1,0,15,0,            1,0,15,0,     0,0,0,0,0);
      // first grant to CPU: store, then load with one stall cycle
      vecs[2]  = mk(0, 1,1,15,32'hDEADBEEF, 1,0,15,0,     1,0,0,0,0);
      vecs[3]  = mk(0, 1,0,15,0,            1,0,15,0,     1,1,0,0,0);
      vecs[4]  = mk(0, 1,0,15,0,            1,0,15,0,     1,0,0,32'hDEADBEEF,0);
      vecs[5]  = mk(0, 0,0,0,0,             0,0,0,0,      0,0,1,0,32'hDEADBEEF);
      // store stream starves DBG until the fifth IDLE cycle
      for (int i = 0; i < 4; i++)
         vecs[6+i] = mk(0, 1,1,20+i,DW'(i+1), 1,0,15,0,   1,0,0,0,0);
      vecs[10] = mk(0, 1,1,24,5,            1,0,15,0,     1,1,0,0,0);
      vecs[11] = mk(0, 1,1,24,5,            0,0,0,0,      1,0,1,0,32'hDEADBEEF);
      // overlap of CPU load completion with DBG read issue
      vecs[12] = mk(0, 1,1,3,32'h11,        0,0,0,0,      1,0,0,0,0);
      vecs[13] = mk(0, 1,1,4,32'h22,        0,0,0,0,      1,0,0,0,0);
      vecs[14] = mk(0, 1,0,3,0,             1,0,4,0,      1,1,0,0,0);
      vecs[15] = mk(0, 1,0,3,0,             1,0,4,0,      1,0,0,32'h11,0);
      vecs[16] = mk(0, 0,0,0,0,             0,0,0,0,      0,0,1,0,32'h22);
      // DBG write visible to CPU load issued in the ack cycle
      vecs[17] = mk(0, 0,0,0,0,             1,1,7,32'h5A, 1,0,0,0,0);
      vecs[18] = mk(0, 1,0,7,0,             0,0,0,0,      1,1,1,0,0);
      vecs[19] = mk(0, 1,0,7,0,             0,0,0,0,      0,0,0,32'h5A,0);
      // reset in the DBG_ACK cycle drops the ack
      vecs[20] = mk(0, 0,0,0,0,             1,0,7,0,      1,0,0,0,0);
      vecs[21] = mk(1, 1,0,7,0,             0,0,0,0,      0,0,0,0,0);
      vecs[22] = mk(0, 0,0,0,0,             0,0,0,0,      0,0,0,0,0);
      vecs[23] = mk(0, 1,0,7,0,             0,0,0,0,      1,1,0,0,0);
      vecs[24] = mk(0, 1,0,7,0,             0,0,0,0,      0,0,0,32'h5A,0);

      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         exp_t e;
         rst      = vecs[i].rst;
         cpu_req  = vecs[i].creq;  cpu_we   = vecs[i].cwe;
         cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
         dbg_req  = vecs[i].dreq;  dbg_we   = vecs[i].dwe;
         dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
         sb.push_back(vecs[i].e);
         @(negedge clk);
         e = sb.pop_front();
         n_vec++;
         chk1(i, "mem_en",    DW'(mem_en),    DW'(e.en));
         chk1(i, "cpu_stall", DW'(cpu_stall), DW'(e.stall));
         chk1(i, "dbg_ack",   DW'(dbg_ack),   DW'(e.ack));
         chk1(i, "cpu_rdata", cpu_rdata,      e.crd);
         chk1(i, "dbg_rdata", dbg_rdata,      e.drd);
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port) in the RISC-V pipeline. It issues at most one synchronous-memory access per cycle and gives the CPU priority, with a bounded-wait guarantee for DBG. It stalls the pipeline for the one-cycle read latency and whenever the CPU loses arbitration. It sits between `riscv_pipeline`'s MEM stage and the data memory array.

## Interface
- `ADDR_W`, 8, word address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, cycles DBG may be denied before it wins over the CPU; legal range is at least 1
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  MEM stage needs an access this cycle
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_rdata`  out  DATA_W  load data, valid in the CPU_RD cycle, otherwise 0
- `cpu_stall`  out  1  combinational; holds the IF, ID, EX and MEM pipeline registers
- `dbg_req`  in  1  level request, held until `dbg_ack`
- `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/ADDR_W/DATA_W  DBG access fields
- `dbg_ack`  out  1  one-cycle completion pulse
- `dbg_rdata`  out  DATA_W  read data, valid with `dbg_ack` on a read, otherwise 0
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  memory address and write data
- `mem_rdata`  in  DATA_W  synchronous read data, valid the cycle after a read issue

## Operation
- **State.** The FSM state records who issued last cycle: IDLE, CPU_RD (CPU read issued), or DBG_ACK (DBG access issued).
- **Issue slot.** Exactly one requester may issue per cycle.
  - In CPU_RD, the held `cpu_req` is the same access and is not reissued. The slot is open to DBG only.
  - In DBG_ACK, the held `dbg_req` is ignored. The slot is open to the CPU only.
  - In IDLE, the CPU wins unless `wait_cnt == MAX_WAIT` and `dbg_req` is high, in which case DBG wins.
- **Next state.**
  - CPU read issued: CPU_RD.
  - DBG access issued: DBG_ACK.
  - CPU write issued, or nothing issued: IDLE.
- **`cpu_stall`** = `cpu_req` and one of the following:
  - a read is issued this cycle, or
  - the CPU is eligible (IDLE or DBG_ACK state) but not granted.
  
  `cpu_stall` is 0 in CPU_RD, when `cpu_rdata = mem_rdata`. A CPU write that is granted does not stall.
- **DBG completion.** In DBG_ACK, `dbg_ack = 1`. For a read, `dbg_rdata = mem_rdata`. The DBG requester drops or changes `dbg_req` from the next cycle.
- **`wait_cnt`.**
  - Increments, saturating at `MAX_WAIT`, in each IDLE cycle where `dbg_req` is high and DBG is denied.
  - Clears on a DBG grant and whenever `dbg_req` is low.
  - Holds in CPU_RD and DBG_ACK.
- **Memory mux.** The `mem_*` outputs are driven by the granted port's fields. When nothing issues they are `mem_en = 0`, `mem_we = 0`, address and data 0.

## Timing
- **Reset.** While `rst` is high: `mem_en = 0`, `cpu_stall = 0`, `dbg_ack = 0`, and all data outputs 0. On the clock edge, state goes to IDLE and `wait_cnt` to 0.
  - Reset mid-operation: a pending `dbg_ack` or CPU_RD completion is dropped and no access issues in the reset cycle.
- **CPU load.** Issue in cycle N with stall high. Data and stall low in N+1. The pipeline advances at the end of N+1. Latency is 2 cycles per load.
- **CPU store.** Written at the end of its issue cycle; zero stall.
- **DBG access.** Issue in N, ack in N+1. A DBG write is visible to a read issued in N+1.
- **Back-to-back CPU loads.** The second load issues in the cycle after CPU_RD; DBG may take the CPU_RD slot.
- **Worst-case DBG wait.** With continuous CPU traffic, DBG is granted within `MAX_WAIT` + 2 cycles.
- **Overlap.** In a CPU_RD cycle where a DBG read issues, `cpu_rdata` comes from the older CPU read, and the DBG read data returns in N+1.

## Structure
- Put in the shared `riscv_mem_pkg`:
  - the state encoding (IDLE, CPU_RD, DBG_ACK), as a 2-bit enum-style localparam set
  - the default `ADDR_W` and `DATA_W`
- One natural sub-module: `dmem_wait_counter`, the saturating `wait_cnt` with its inc/clear/hold controls and a `starved` output.
- Everything else (grant logic, FSM, output muxes) stays in `dmem_arbiter`.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `cpu_req = 1`, `dbg_req = 1` → `mem_en = 0`, `cpu_stall = 0`, `dbg_ack = 0` throughout. The first grant after release goes to the CPU.
- **CPU store then load.** Store 0xDEADBEEF to addr 15 → no stall. Load addr 15 → stall exactly 1 cycle, then `cpu_rdata = 0xDEADBEEF`.
- **DBG starvation, `MAX_WAIT = 4`.** CPU issues a store every cycle with `dbg_req` high → DBG is granted on the 5th IDLE cycle, the CPU sees `cpu_stall = 1` that cycle, and `dbg_ack` follows 1 cycle later.
- **Overlap.** CPU load of addr 3 (holding 0x11) in N, DBG read of addr 4 (holding 0x22) → DBG issues in N+1 with `cpu_rdata = 0x11`; in N+2, `dbg_ack = 1` and `dbg_rdata = 0x22`.
- **DBG write / CPU read ordering.** DBG write 0x5A to addr 7 acked, CPU load of addr 7 in the ack cycle → `cpu_rdata = 0x5A`.
- **Reset mid-operation.** Assert `rst` in a DBG_ACK cycle → no `dbg_ack` pulse, and the state is IDLE after the edge.
